dlx_data_mem: RTL and testbench

DLX_DATA_MEM -- requirements
Module: dlx_data_mem

---
 rtl/dlx_data_mem.sv | 258 +++++++++++++++++++++++++
 tb/tb_dlx_data_mem.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_data_mem.sv
// dlx_data_mem: multi-cycle big-endian byte-addressable data memory for a DLX core.
//
// Protocol: IDLE -> (WAIT x WAIT_CYCLES) -> DONE -> IDLE. Ready pulses in DONE.
// Read data is captured and write data committed on the edge that enters DONE.
//
// The array is split into four byte-lane banks (bank n holds bytes whose
// address ends in n). Every accepted access is aligned, so all of its bytes
// sit in one row of the four banks and can be written in a single edge.
//
// Optional build macro: DLX_MEM_ALIGN_CHECK_EN
//   defined   : misaligned halfword/word and out-of-range addresses raise Fault
//   undefined : low address bits are forced to alignment, high bits wrap
module dlx_data_mem #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic [31:0] MemData,
    output logic        Ready,
    output logic        Busy,
    output logic        Fault
);

    localparam int ROW_W = ADDR_W - 2;
    localparam int DEPTH = 1 << ROW_W;
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [31:0]         wdata_reg;
    logic [1:0]          size_reg;
    logic                uns_reg;
    logic                write_reg;
    logic [31:0]         mem_data_reg;
    logic                ready_reg;
    logic                busy_reg;
    logic                fault_reg;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] req_addr;
    logic              align_bad;
    logic              accept;
    logic              reject;

    // Aligned, wrapped byte address of the incoming request.
    always_comb begin
        req_addr = Address[ADDR_W-1:0];
        if (Size == SZ_HALF) begin
            req_addr[0] = 1'b0;
        end else if (Size == SZ_WORD) begin
            req_addr[1:0] = 2'b00;
        end
    end

`ifdef DLX_MEM_ALIGN_CHECK_EN
    assign align_bad = ((Size == SZ_HALF) && Address[0])
                    || ((Size == SZ_WORD) && (Address[1:0] != 2'b00))
                    || (|Address[31:ADDR_W]);
`else
    // High address bits are deliberately discarded: the array wraps.
    logic unused_high;
    assign unused_high = ^Address[31:ADDR_W];
    assign align_bad   = 1'b0;
`endif

    assign accept = (MemRead ^ MemWrite) && (Size != SZ_RSVD) && !align_bad;
    assign reject = (MemRead | MemWrite) && !accept;

    // ------------------------------------------------------------------
    // Current access: with no wait states the commit edge is the accepting
    // edge, so the live request is used; otherwise the latched copy.
    // ------------------------------------------------------------------
    logic              use_live;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [1:0]        acc_size;
    logic              acc_uns;
    logic              acc_write;
    logic              go_done;
    logic              commit_wr;
    logic              capture_rd;
    logic [ROW_W-1:0]  row;
    logic [1:0]        lane;

    assign use_live  = (WAIT_CYCLES == 0) && (state_reg == IDLE);
    assign acc_addr  = use_live ? req_addr  : addr_reg;
    assign acc_wdata = use_live ? WriteData : wdata_reg;
    assign acc_size  = use_live ? Size      : size_reg;
    assign acc_uns   = use_live ? Unsigned  : uns_reg;
    assign acc_write = use_live ? MemWrite  : write_reg;

    // Reset_n gating keeps a reset edge from ever committing a write.
    assign go_done = Reset_n
                  && ((use_live && accept)
                   || ((state_reg == WAIT) && (cnt_reg == WAIT_LAST)));
    assign commit_wr  = go_done &&  acc_write;
    assign capture_rd = go_done && !acc_write;

    assign row  = acc_addr[ADDR_W-1:2];
    assign lane = acc_addr[1:0];

    // ------------------------------------------------------------------
    // Byte-lane banks (no reset: contents survive Reset_n)
    // ------------------------------------------------------------------
    logic [7:0] rd_lane [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            localparam logic [1:0] LANE = 2'(gi);
            logic [7:0] mem [DEPTH];
            logic       we;
            logic [7:0] wd;

            // Big-endian lane steering: the lowest address takes the MSB.
            always_comb begin
                we = 1'b0;
                wd = acc_wdata[7:0];
                case (acc_size)
                    SZ_BYTE: begin
                        we = (lane == LANE);
                        wd = acc_wdata[7:0];
                    end
                    SZ_HALF: begin
                        we = (lane[1] == LANE[1]);
                        wd = LANE[0] ? acc_wdata[7:0] : acc_wdata[15:8];
                    end
                    SZ_WORD: begin
                        we = 1'b1;
                        wd = acc_wdata[8*(3-gi) +: 8];
                    end
                    default: begin
                        we = 1'b0;
                    end
                endcase
            end

            // Bank write port, committed on the edge entering DONE.
            always_ff @(posedge Clock) begin
                if (commit_wr && we) begin
                    mem[row] <= wd;
                end
            end

            assign rd_lane[gi] = mem[row];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read assembly and extension
    // ------------------------------------------------------------------
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    // Assemble the big-endian value and sign/zero-extend sub-word reads.
    always_comb begin
        rd_byte = rd_lane[lane];
        rd_half = lane[1] ? {rd_lane[2], rd_lane[3]} : {rd_lane[0], rd_lane[1]};
        case (acc_size)
            SZ_BYTE: rd_ext = acc_uns ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            SZ_HALF: rd_ext = acc_uns ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = {rd_lane[0], rd_lane[1], rd_lane[2], rd_lane[3]};
        endcase
    end

    // ------------------------------------------------------------------
    // Access FSM with registered status outputs
    // ------------------------------------------------------------------

    // Sequences IDLE/WAIT/DONE, latches requests and drives Ready/Busy/Fault.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            addr_reg     <= '0;
            wdata_reg    <= 32'd0;
            size_reg     <= 2'b00;
            uns_reg      <= 1'b0;
            write_reg    <= 1'b0;
            mem_data_reg <= 32'd0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            fault_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg  <= req_addr;
                        wdata_reg <= WriteData;
                        size_reg  <= Size;
                        uns_reg   <= Unsigned;
                        write_reg <= MemWrite;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= 4'd0;
                        if (WAIT_CYCLES == 0) begin
                            state_reg <= DONE;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end else if (reject) begin
                        fault_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_reg == WAIT_LAST) begin
                        state_reg <= DONE;
                        ready_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    cnt_reg   <= 4'd0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
            if (capture_rd) begin
                mem_data_reg <= rd_ext;
            end
        end
    end

    assign MemData = mem_data_reg;
    assign Ready   = ready_reg;
    assign Busy    = busy_reg;
    assign Fault   = fault_reg;

endmodule

// File: tb/tb_dlx_data_mem.sv
// Bench for dlx_data_mem: one instance with two wait states, one with none.
// A byte-array reference model (big-endian, plain arithmetic) predicts reads.
module tb_dlx_data_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0]       mrd;
    logic [1:0]       mwr;
    logic [1:0]       uns;
    logic [1:0][1:0]  size;
    wire  [1:0][31:0] mdata;
    wire  [1:0]       ready;
    wire  [1:0]       busy;
    wire  [1:0]       fault;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem_m [2][1024];

    dlx_data_mem #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_w2 (
        .Clock(clk), .Reset_n(rst_n), .Address(addr[0]), .WriteData(wdata[0]),
        .MemRead(mrd[0]), .MemWrite(mwr[0]), .Size(size[0]), .Unsigned(uns[0]),
        .MemData(mdata[0]), .Ready(ready[0]), .Busy(busy[0]), .Fault(fault[0])
    );

    dlx_data_mem #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_w0 (
        .Clock(clk), .Reset_n(rst_n), .Address(addr[1]), .WriteData(wdata[1]),
        .MemRead(mrd[1]), .MemWrite(mwr[1]), .Size(size[1]), .Unsigned(uns[1]),
        .MemData(mdata[1]), .Ready(ready[1]), .Busy(busy[1]), .Fault(fault[1])
    );

    function automatic int exp_lat(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic int eff_addr(input logic [31:0] a, input logic [1:0] sz);
        int nb = 1 << sz;
        int e  = int'(a % 32'd1024);
        return e - (e % nb);
    endfunction

    function automatic logic [31:0] model_read(input int d, input int ea,
                                               input logic [1:0] sz, input logic u);
        int     nb = 1 << sz;
        longint v  = 0;
        for (int i = 0; i < nb; i++) v = v * 256 + longint'(mem_m[d][ea + i]);
        if (!u && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        return 32'(v);
    endfunction

    task automatic model_write(input int d, input int ea, input logic [1:0] sz,
                               input logic [31:0] wd);
        int nb = 1 << sz;
        for (int i = 0; i < nb; i++) mem_m[d][ea + i] = 8'(wd >> (8 * (nb - 1 - i)));
    endtask

    // One complete access; returns cycles from accepting edge to Ready (-1 on timeout).
    task automatic access(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic u,
                          output int lat, output logic [31:0] rdata);
        @(negedge clk);
        addr[d] = a; wdata[d] = wd; size[d] = sz; uns[d] = u;
        mrd[d] = !wr; mwr[d] = wr;
        @(posedge clk);
        @(negedge clk);
        mrd[d] = 1'b0; mwr[d] = 1'b0;
        lat = 1;
        while (!ready[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!ready[d]) lat = -1;
        rdata = mdata[d];
        $display("[TB] dut%0d %s a=%h sz=%0d u=%0d wd=%h lat=%0d data=%h",
                 d, wr ? "WR" : "RD", a, sz, u, wd, lat, rdata);
    endtask

    // Present a request for exactly one edge, then sample at the next negedge.
    task automatic drive_one(input int d, input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [1:0] sz);
        @(negedge clk);
        addr[d] = a; wdata[d] = wd; size[d] = sz; uns[d] = 1'b0;
        mrd[d] = rd; mwr[d] = wr;
        @(posedge clk);
        @(negedge clk);
        mrd[d] = 1'b0; mwr[d] = 1'b0;
        $display("[TB] dut%0d pulse rd=%0d wr=%0d a=%h sz=%0d fault=%0d busy=%0d",
                 d, rd, wr, a, sz, fault[d], busy[d]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if ({mdata[d], ready[d], busy[d], fault[d]} !== 35'd0) begin
                fails++;
                $display("FAIL reset_outputs dut%0d: got %h want 0", d,
                         {mdata[d], ready[d], busy[d], fault[d]});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (busy[d] !== 1'b0 || ready[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_release dut%0d: busy=%b ready=%b want 0 0", d, busy[d], ready[d]);
            end
        end
    endtask

    task automatic test_directed();
        int lat;
        logic [31:0] rd;
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, lat, rd);
        model_write(0, 16, 2'b10, 32'hDEADBEEF);
        tests++;
        if (lat != 3) begin fails++; $display("FAIL wr_word_lat: got %0d want 3", lat); end
        access(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, lat, rd);
        tests++;
        if (lat != 3 || rd !== 32'hDEADBEEF) begin
            fails++; $display("FAIL rd_word: lat %0d data %h want 3 deadbeef", lat, rd);
        end
        access(0, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, lat, rd);
        tests++;
        if (rd !== 32'hFFFFFFDE) begin fails++; $display("FAIL rd_byte_signed: got %h want ffffffde", rd); end
        access(0, 1'b0, 32'h12, 32'h0, 2'b01, 1'b1, lat, rd);
        tests++;
        if (rd !== 32'h0000BEEF) begin fails++; $display("FAIL rd_half_unsigned: got %h want 0000beef", rd); end
        access(0, 1'b1, 32'h11, 32'hAAAAAA55, 2'b00, 1'b0, lat, rd);
        model_write(0, 17, 2'b00, 32'hAAAAAA55);
        tests++;
        if (rd !== 32'h0000BEEF) begin fails++; $display("FAIL wr_keeps_memdata: got %h want 0000beef", rd); end
        access(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, lat, rd);
        tests++;
        if (rd !== 32'hDE55BEEF) begin fails++; $display("FAIL rd_after_byte_wr: got %h want de55beef", rd); end
    endtask

    task automatic test_fault();
        int lat;
        logic [31:0] rd;
        drive_one(0, 1'b1, 1'b1, 32'h10, 32'h0, 2'b10);
        tests++;
        if (fault[0] !== 1'b1 || busy[0] !== 1'b0) begin
            fails++; $display("FAIL both_req: fault=%b busy=%b want 1 0", fault[0], busy[0]);
        end
        tests++;
        if (mdata[0] !== 32'hDE55BEEF) begin fails++; $display("FAIL fault_keeps_memdata: got %h want de55beef", mdata[0]); end
        @(negedge clk);
        tests++;
        if (fault[0] !== 1'b0) begin fails++; $display("FAIL fault_one_cycle: got %b want 0", fault[0]); end
        drive_one(0, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 2'b11);
        tests++;
        if (fault[0] !== 1'b1 || busy[0] !== 1'b0) begin
            fails++; $display("FAIL size_reserved: fault=%b busy=%b want 1 0", fault[0], busy[0]);
        end
        access(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, lat, rd);
        tests++;
        if (rd !== 32'hDE55BEEF) begin fails++; $display("FAIL fault_no_mem_change: got %h want de55beef", rd); end
`ifdef DLX_MEM_ALIGN_CHECK_EN
        drive_one(0, 1'b1, 1'b0, 32'h12, 32'h0, 2'b10);
        tests++;
        if (fault[0] !== 1'b1 || busy[0] !== 1'b0) begin
            fails++; $display("FAIL misaligned_word: fault=%b busy=%b want 1 0", fault[0], busy[0]);
        end
`else
        access(0, 1'b0, 32'h12, 32'h0, 2'b10, 1'b0, lat, rd);
        tests++;
        if (lat != 3 || rd !== 32'hDE55BEEF) begin
            fails++; $display("FAIL misaligned_word_forced: lat %0d data %h want 3 de55beef", lat, rd);
        end
`endif
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [31:0] rd;
        access(0, 1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, lat, rd);
        model_write(0, 32, 2'b10, 32'hCAFEF00D);
        @(negedge clk);
        addr[0] = 32'h20; wdata[0] = 32'h12345678; size[0] = 2'b10; mwr[0] = 1'b1; mrd[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mwr[0] = 1'b0;
        tests++;
        if (busy[0] !== 1'b1) begin fails++; $display("FAIL abort_in_wait: busy=%b want 1", busy[0]); end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({mdata[0], ready[0], busy[0], fault[0]} !== 35'd0) begin
            fails++; $display("FAIL async_reset: got %h want 0", {mdata[0], ready[0], busy[0], fault[0]});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        access(0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, lat, rd);
        tests++;
        if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL abort_no_write: got %h want cafef00d", rd); end
    endtask

    task automatic test_random();
        int lat, ea;
        logic [31:0] rd, a, wd, last_rd;
        logic [1:0] sz;
        logic wr, u, have_rd;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 32; w++) begin
                wd = $urandom();
                access(d, 1'b1, 32'(w * 4), wd, 2'b10, 1'b0, lat, rd);
                model_write(d, w * 4, 2'b10, wd);
                tests++;
                if (lat != exp_lat(d)) begin fails++; $display("FAIL init_lat dut%0d: got %0d want %0d", d, lat, exp_lat(d)); end
            end
            have_rd = 1'b0;
            last_rd = 32'h0;
            for (int n = 0; n < 120; n++) begin
                wr = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 2));
                u  = 1'($urandom_range(0, 1));
                wd = $urandom();
`ifdef DLX_MEM_ALIGN_CHECK_EN
                a = 32'($urandom_range(0, 127)) & ~(32'((1 << sz) - 1));
`else
                a = ($urandom() & 32'hFFFFFC00) | 32'($urandom_range(0, 127));
`endif
                ea = eff_addr(a, sz);
                access(d, wr, a, wd, sz, u, lat, rd);
                tests++;
                if (lat != exp_lat(d)) begin fails++; $display("FAIL rand_lat dut%0d: got %0d want %0d", d, lat, exp_lat(d)); end
                if (wr) begin
                    model_write(d, ea, sz, wd);
                    if (have_rd) begin
                        tests++;
                        if (rd !== last_rd) begin fails++; $display("FAIL rand_wr_memdata dut%0d: got %h want %h", d, rd, last_rd); end
                    end
                end else begin
                    last_rd = model_read(d, ea, sz, u);
                    have_rd = 1'b1;
                    tests++;
                    if (rd !== last_rd) begin
                        fails++; $display("FAIL rand_rd dut%0d a=%h sz=%0d u=%0d: got %h want %h", d, a, sz, u, rd, last_rd);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        exp = model_read(1, 16, 2'b10, 1'b0);
        @(negedge clk);
        addr[1] = 32'h10; size[1] = 2'b10; uns[1] = 1'b0; mwr[1] = 1'b0; mrd[1] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            tests++;
            if (ready[1] !== 1'(k % 2)) begin
                fails++; $display("FAIL b2b_ready cycle %0d: got %b want %0d", k, ready[1], k % 2);
            end
            if (k % 2 == 1) begin
                tests++;
                if (mdata[1] !== exp) begin fails++; $display("FAIL b2b_data cycle %0d: got %h want %h", k, mdata[1], exp); end
            end
        end
        mrd[1] = 1'b0;
        $display("[TB] dut1 back-to-back reads of %h done", exp);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        addr = '0; wdata = '0; mrd = '0; mwr = '0; uns = '0; size = '0;
        rst_n = 1'b0;
        test_reset();
        test_directed();
        test_fault();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
